// File: rtl/hex_display_bank.sv
// hex_display_bank
// Multi-digit hexadecimal driver for active-low seven-segment displays.
// A packed value is accepted through a valid/ready handshake. The block decodes
// one digit per cycle into a staging bank, then commits the whole bank to the
// display register in a single cycle, so a partial update is never visible.
// An optional blink blanks the whole display on alternate half-periods.
//
// Ports:
//   clock       in   system clock, all state on rising edge
//   resetn      in   synchronous active-low reset
//   data_in     in   4*DIGITS packed value, nibble i -> digit i
//   load_valid  in   request to display data_in
//   load_ready  out  block can accept a load this cycle
//   blink_en    in   1 = blink whole display, 0 = steady
//   busy        out  decode/commit in progress
//   hex_out     out  7*DIGITS segments (active low), bits 7i+0..6 = a..g of digit i
//
// Build option: HEX_DISPLAY_BLANK_EN enables leading-zero blanking of digits >= 1.
//
// state  | meaning
// IDLE   | ready for a load, display steady
// DECODE | writing glyph of shadow nibble idx into staging slot idx
// COMMIT | copying staging bank to the display register
module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  blink_en,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7*DIGITS-1:0]   staging_q, staging_d;
  logic [7*DIGITS-1:0]   display_q, display_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [3:0]            nib_sel;
  logic                  blank_sel;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

`ifdef HEX_DISPLAY_BLANK_EN
  // zero_up[i]: nibble i and every higher nibble of shadow are zero.
  logic [DIGITS-1:0] zero_up;
  always_comb begin
    logic run;
    run = 1'b1;
    zero_up = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run & (shadow_q[4*i +: 4] == 4'h0);
      zero_up[i] = run;
    end
  end
`endif

  // Nibble and blank decision for the slot currently being decoded.
  always_comb begin
    nib_sel   = '0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel = shadow_q[4*i +: 4];
`ifdef HEX_DISPLAY_BLANK_EN
        blank_sel = (i != 0) && zero_up[i];
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    staging_d = staging_q;
    display_d = display_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shadow_d = data_in;
          idx_d    = '0;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            staging_d[7*i +: 7] = blank_sel ? BLANK : glyph(nib_sel);
          end
        end
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          idx_d   = '0;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      COMMIT: begin
        display_d = staging_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink runs independently of the FSM.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (blink_en) begin
      if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      staging_q <= {DIGITS{BLANK}};
      display_q <= {DIGITS{BLANK}};
      cnt_q     <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      display_q <= display_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign hex_out    = phase_q ? '1 : display_q;

endmodule

// File: tb/tb_hex_display_bank.sv
module tb_hex_display_bank;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;
  localparam logic [41:0] DARK = '1;

  logic                clock = 1'b0;
  logic                resetn;
  logic [4*DIGITS-1:0] data_in;
  logic                load_valid;
  logic                load_ready;
  logic                blink_en;
  logic                busy;
  logic [7*DIGITS-1:0] hex_out;

  int errors = 0;
  int checks = 0;
  logic [41:0] cur_disp;

  hex_display_bank #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blink_en   (blink_en),
    .busy       (busy),
    .hex_out    (hex_out)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout hex_out=%h", hex_out);
    $fatal(1, "timeout");
  end

  // Reference glyph table, index = hex digit value.
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [41:0] model(input logic [23:0] v);
    logic [41:0] r;
    int unsigned val, nib, upper;
    bit blank;
    r = '0;
    val = 32'(v);
    for (int i = 0; i < DIGITS; i++) begin
      nib   = (val >> (4 * i)) % 16;
      upper = val >> (4 * i);
      blank = 1'b0;
`ifdef HEX_DISPLAY_BLANK_EN
      blank = (i >= 1) && (upper == 0);
`endif
      r[7*i +: 7] = blank ? 7'h7F : glyph_tab[nib];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Load v with single-cycle valid; checks the display holds until commit.
  task automatic load_and_check(input logic [23:0] v, input string tag);
    data_in    = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = 24'(~v);
    check({tag, "_busy"}, 64'(busy), 64'(1'b1));
    for (int c = 1; c <= DIGITS; c++) begin
      tick();
      check({tag, "_hold"}, 64'(hex_out), 64'(cur_disp));
    end
    tick();
    cur_disp = model(v);
    check({tag, "_commit"}, 64'(hex_out), 64'(cur_disp));
    check({tag, "_ready"}, 64'(load_ready), 64'(1'b1));
  endtask

  initial begin
    logic [23:0] va, vb, rv;
    resetn = 1'b0; load_valid = 1'b0; blink_en = 1'b0; data_in = '0;
    #1;
    tick(); tick();
    check("rst_hex", 64'(hex_out), 64'(DARK));
    check("rst_ready", 64'(load_ready), 64'(1'b1));
    check("rst_busy", 64'(busy), 64'(1'b0));
    resetn = 1'b1;
    cur_disp = DARK;
    tick();
    check("idle_hex", 64'(hex_out), 64'(DARK));

    // Directed value from the plan.
    load_and_check(24'h0123AF, "ld0123AF");
    load_and_check(24'h000000, "ld000000");
    load_and_check(24'hFEDCBA, "ldFEDCBA");
    load_and_check(24'h000010, "ld000010");

    // Random values, including some with leading zeros.
    for (int n = 0; n < 8; n++) begin
      rv = 24'($urandom) >> (4 * $urandom_range(0, 6));
      load_and_check(rv, "ldrand");
    end

    // load_valid held through busy: the second value waits for ready.
    va = 24'($urandom); vb = 24'($urandom);
    data_in = va; load_valid = 1'b1;
    tick();
    data_in = vb;
    for (int c = 1; c <= DIGITS; c++) begin
      tick();
      check("held_hold_a", 64'(hex_out), 64'(cur_disp));
    end
    tick();
    cur_disp = model(va);
    check("held_commit_a", 64'(hex_out), 64'(cur_disp));
    tick();
    load_valid = 1'b0;
    check("held_accept_b", 64'(busy), 64'(1'b1));
    for (int c = 1; c <= DIGITS; c++) begin
      tick();
      check("held_hold_b", 64'(hex_out), 64'(cur_disp));
    end
    tick();
    cur_disp = model(vb);
    check("held_commit_b", 64'(hex_out), 64'(cur_disp));

    // Blink: phase after n enabled edges is floor(n/BLINK_DIV) mod 2.
    blink_en = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      tick();
      check("blink", 64'(hex_out), ((n / BLINK_DIV) % 2) ? 64'(DARK) : 64'(cur_disp));
    end
    blink_en = 1'b0;
    tick();
    check("blink_off", 64'(hex_out), 64'(cur_disp));

    // blink_en raised in the commit cycle: commit lands, blink starts fresh.
    va = 24'($urandom);
    data_in = va; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c <= DIGITS; c++) tick();
    blink_en = 1'b1;
    tick();
    cur_disp = model(va);
    check("cblink_commit", 64'(hex_out), 64'(cur_disp));
    for (int n = 2; n <= 9; n++) begin
      tick();
      check("cblink", 64'(hex_out), ((n / BLINK_DIV) % 2) ? 64'(DARK) : 64'(cur_disp));
    end
    blink_en = 1'b0;
    tick();
    check("cblink_off", 64'(hex_out), 64'(cur_disp));

    // Reset on the third DECODE cycle discards the in-flight value.
    va = 24'($urandom) | 24'h1;
    data_in = va; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    check("mid_hold1", 64'(hex_out), 64'(cur_disp));
    tick();
    check("mid_hold2", 64'(hex_out), 64'(cur_disp));
    resetn = 1'b0;
    tick();
    check("mid_rst_hex", 64'(hex_out), 64'(DARK));
    check("mid_rst_ready", 64'(load_ready), 64'(1'b1));
    check("mid_rst_busy", 64'(busy), 64'(1'b0));
    resetn = 1'b1;
    cur_disp = DARK;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("mid_dark", 64'(hex_out), 64'(DARK));
    end
    check("mid_idle", 64'(load_ready), 64'(1'b1));

    // Recovers normally after the aborted load.
    load_and_check(24'h5A5A00, "ld_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Parametrised multi-digit hexadecimal display driver for the board's active-low seven-segment displays. It accepts a packed value through a valid/ready handshake and decodes it one digit per cycle into a staging bank. It then commits all digits to the display atomically, so a partial update is never visible. It also provides an optional blink function and optional leading-zero blanking, and sits between datapath result registers and the HEX outputs.

## Interface
- DIGITS, 6, number of displayed hex digits (legal 1..8)
- BLINK_DIV, 25000000, clock cycles per blink half-period (legal ≥2)

- clock  in  1  single system clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- data_in  in  4*DIGITS  packed value; nibble i drives digit i (digit 0 = least significant)
- load_valid  in  1  request to display data_in
- load_ready  out  1  block can accept a load this cycle
- blink_en  in  1  1 = blink whole display, 0 = steady
- busy  out  1  decode/commit in progress
- hex_out  out  7*DIGITS  segments, active low; bits 7i+0..7i+6 = segments a..g of digit i

## Operation
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-low: resetn sampled low at a rising edge of clock resets the block.
- State machine:
  - IDLE: load_ready=1, busy=0. On load_valid=1 at an edge, capture data_in into shadow register, set digit index to 0, go to DECODE.
  - DECODE: load_ready=0, busy=1. Each cycle writes glyph(shadow nibble idx) into staging slot idx, then idx++. After slot DIGITS-1 is written, go to COMMIT.
  - COMMIT: load_ready=0, busy=1. Copy the whole staging bank to the display register, go to IDLE.
- load_valid while not ready is ignored: no queueing, no error.
- Glyphs (g..a, active low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
  - Blank = 0x7F.
- Blink:
  - While blink_en=1, a counter counts 0..BLINK_DIV-1 and toggles the phase bit on wrap.
  - Phase=1 forces hex_out to all ones.
  - blink_en=0 clears the counter and phase to 0 in the same cycle.
  - Blink runs independently of the FSM; a load during blink does not reset the phase.
- hex_out = phase ? all ones : display register. Combinational from registers only.

## Timing
- Reset values:
  - hex_out all ones (all digits dark)
  - load_ready=1, busy=0
  - shadow, staging and display registers: display = blank, staging = blank, shadow = 0
  - blink counter 0, phase 0, FSM IDLE
- Load latency:
  - Load accepted at edge k.
  - Staging slots are written at edges k+1..k+DIGITS.
  - Commit occurs at edge k+DIGITS+1; the new value is on hex_out immediately after that edge.
  - load_ready returns to 1 after the commit edge, so the next load can be accepted at edge k+DIGITS+2.
- Boundary conditions:
  - Staging writes never affect hex_out before COMMIT.
  - DIGITS=1: DECODE lasts exactly one cycle.
  - Reset asserted mid-DECODE or mid-COMMIT: returns to IDLE with the reset values above; the in-flight value is discarded and the display goes dark.
  - blink_en toggled in the same cycle as a commit: the commit lands; phase follows the blink rules independently.

## Configuration
- HEX_DISPLAY_BLANK_EN defined:
  - Digit i (i ≥ 1) shows blank (0x7F) when its nibble and every higher nibble in shadow are zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking is evaluated during DECODE from shadow.
- Undefined: all digits always show their glyph, including leading zeros.

## Test plan
- Reset with resetn=0 for 2 edges -> hex_out all ones (42'h3FFFFFFFFFF for DIGITS=6), load_ready=1, busy=0.
- DIGITS=6, load 24'h0123AF at edge k -> hex_out unchanged through edge k+6; after edge k+7, digits 5..0 = 0x40,0x79,0x24,0x30,0x08,0x0E (undefined macro); with HEX_DISPLAY_BLANK_EN, digit 5 = 0x7F.
- Load 24'h000000 with HEX_DISPLAY_BLANK_EN -> digits 5..1 = 0x7F, digit 0 = 0x40.
- Second load_valid=1 held during busy -> ignored; only after load_ready=1 is the new value captured; hex_out shows the first value until the second commit.
- BLINK_DIV=4, blink_en=1 -> hex_out alternates display value / all ones every 4 cycles; blink_en=0 -> steady display the next cycle.
- resetn=0 on the third DECODE cycle -> next cycle IDLE, hex_out all ones, load_ready=1; no partial digits ever appear.
